atomic_mem_responder: RTL

//  Cache-side responder for the atomic unit's cache port. Accepts word reads and

---
 rtl/atomic_mem_responder.sv | 98 +++++++++
 1 files changed

// File: rtl/atomic_mem_responder.sv
// Word-addressed backing array behind the atomic unit's cache port: reads return
// after a fixed LAT-deep pipe, writes commit on acceptance, with sticky error flags.
module atomic_mem_responder #(
  parameter int ADDR_W     = 40,
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 8,
  parameter int LAT        = 2,
  parameter int MAX_OUT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_req_valid,
  output logic              cache_req_ready,
  input  logic [ADDR_W-1:0] cache_req_addr,
  input  logic              cache_req_we,
  input  logic [DATA_W-1:0] cache_req_wdata,
  output logic              cache_resp_valid,
  output logic [DATA_W-1:0] cache_resp_data,
  output logic              err_misaligned,
  output logic              err_range,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int EFF_OUT = (MAX_OUT < 1) ? 1 : ((MAX_OUT > LAT) ? LAT : MAX_OUT);
  localparam int IF_W    = $clog2(LAT + 1) + 1;
  localparam logic [IF_W-1:0] EFF_OUT_V = IF_W'(EFF_OUT);

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [LAT-1:0]      r_vld_p;
  logic [DATA_W-1:0]   r_data_p [LAT];
  logic [DATA_W-1:0]   r_hold;
  logic [IF_W-1:0]     r_inflight;
  logic                r_err_mis;
  logic                r_err_rng;
  logic [31:0]         r_rd_cnt;
  logic [31:0]         r_wr_cnt;

  logic                  w_acc;
  logic                  w_acc_rd;
  logic                  w_acc_wr;
  logic                  w_retire;
  logic                  w_misaligned;
  logic                  w_oor;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DATA_W-1:0]     w_rd_word;

  assign w_idx        = cache_req_addr[DEPTH_LOG2+2:3];
  assign w_misaligned = (cache_req_addr[2:0] != 3'b000);
  assign w_oor        = (cache_req_addr[ADDR_W-1:DEPTH_LOG2+3] != '0);
  assign w_retire     = r_vld_p[LAT-1];

  // A retiring read frees its slot in the same cycle, so back-to-back issue is possible.
  assign cache_req_ready = ~rst & ((r_inflight < EFF_OUT_V) | w_retire);
  assign w_acc     = cache_req_valid & cache_req_ready;
  assign w_acc_rd  = w_acc & ~cache_req_we;
  assign w_acc_wr  = w_acc & cache_req_we;
  assign w_rd_word = w_oor ? '0 : r_mem[w_idx];

  assign cache_resp_valid = w_retire;
  assign cache_resp_data  = w_retire ? r_data_p[LAT-1] : r_hold;

  // Stage boundary: accept edge -> pipe stage 1; array and read data carry no reset.
  always_ff @(posedge clk) begin
    if (w_acc_wr && !w_oor) r_mem[w_idx] <= cache_req_wdata;
    r_data_p[0] <= w_rd_word;
    for (int i = 1; i < LAT; i++) r_data_p[i] <= r_data_p[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p    <= '0;
      r_hold     <= '0;
      r_inflight <= '0;
      r_err_mis  <= 1'b0;
      r_err_rng  <= 1'b0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
    end else begin
      r_vld_p[0] <= w_acc_rd;
      for (int i = 1; i < LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
      if (w_retire) r_hold <= r_data_p[LAT-1];
      if (w_acc_rd && !w_retire)      r_inflight <= r_inflight + 1'b1;
      else if (!w_acc_rd && w_retire) r_inflight <= r_inflight - 1'b1;
      if (w_acc && w_misaligned) r_err_mis <= 1'b1;
      if (w_acc && w_oor)        r_err_rng <= 1'b1;
      if (w_acc_rd) r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_acc_wr) r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end

  assign err_misaligned = r_err_mis;
  assign err_range      = r_err_rng;
  assign rd_cnt         = r_rd_cnt;
  assign wr_cnt         = r_wr_cnt;

endmodule
